// File: rtl/pre_if_stage_pkg.sv
// pre_if_stage_pkg: reset PC, IF data width and pre-fetch FSM state encodings
package pre_if_stage_pkg;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int to_IF_data_width = 32;
  typedef enum logic [1:0] {RESET, RUN, HOLD} state_t;
endpackage

// File: rtl/pre_if_stage_redirect_buf.sv
// preif_redirect_buf: holds one redirect target until IF accepts it; csr targets are never overwritten by branches
module preif_redirect_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        csr_reset,
  input  logic [31:0] csr_target,
  output logic        pend_valid,
  output logic [31:0] pend_pc
);
  logic pend_csr;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_csr   <= 1'b0;
      pend_pc    <= '0;
    end else if (fire) begin
      pend_valid <= 1'b0;
      pend_csr   <= 1'b0;
    end else if (csr_reset) begin
      pend_valid <= 1'b1;
      pend_csr   <= 1'b1;
      pend_pc    <= csr_target;
    end else if (br_taken && !(pend_valid && pend_csr)) begin
      pend_valid <= 1'b1;
      pend_csr   <= 1'b0;
      pend_pc    <= br_target;
    end
  end
endmodule

// File: rtl/pre_if_stage.sv
// pre_if_stage: fetch PC owner, next-PC select and IF handshake; PREIF_FETCH_CNT_EN adds fetch_cnt/redirect_cnt
module pre_if_stage
  import pre_if_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         IF_allow_in,
  output logic                         preIF_to_IF_valid,
  output logic [to_IF_data_width-1:0]  to_IF_data,
  input  logic                         br_taken,
  input  logic [31:0]                  br_target,
  input  logic                         br_stall,
  input  logic                         csr_reset,
  input  logic [31:0]                  csr_target,
  output logic                         inst_sram_en,
  output logic [3:0]                   inst_sram_we,
  output logic [31:0]                  inst_sram_addr,
  output logic [31:0]                  inst_sram_wdata
`ifdef PREIF_FETCH_CNT_EN
  ,
  output logic [31:0]                  fetch_cnt,
  output logic [31:0]                  redirect_cnt
`endif
);
  state_t      state, state_nxt;
  logic [31:0] pc_r, seq_pc, issue_pc, pend_pc;
  logic        pend_valid, run_r, fire, redirect;
  preif_redirect_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .fire       (fire),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .csr_reset  (csr_reset),
    .csr_target (csr_target),
    .pend_valid (pend_valid),
    .pend_pc    (pend_pc)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= RESET;
    else       state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == RESET          ? RUN  :
                fire                    ? RUN  :
                (csr_reset | br_taken)  ? HOLD : state;
  end
  always_comb begin
    run_r             = state != RESET;
    preIF_to_IF_valid = run_r & ~reset & (csr_reset | ~br_stall);
    fire              = preIF_to_IF_valid & IF_allow_in;
    seq_pc            = pc_r + 32'd4;
    issue_pc          = csr_reset  ? csr_target :
                        br_taken   ? br_target  :
                        pend_valid ? pend_pc    : seq_pc;
    redirect          = csr_reset | br_taken | pend_valid;
    to_IF_data        = issue_pc;
    inst_sram_en      = fire;
    inst_sram_we      = '0;
    inst_sram_addr    = {issue_pc[31:2], 2'b00};
    inst_sram_wdata   = '0;
  end
  always_ff @(posedge clk) begin
    if (reset)     pc_r <= RESET_PC - 32'd4;
    else if (fire) pc_r <= issue_pc;
  end
`ifdef PREIF_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else if (fire) begin
      fetch_cnt    <= fetch_cnt + 32'd1;
      redirect_cnt <= redirect_cnt + {31'd0, redirect};
    end
  end
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif
endmodule

// File: tb/tb_pre_if_stage.sv
// tb_pre_if_stage: directed stimulus with a fetch-PC scoreboard and a negedge monitor
module tb_pre_if_stage;
  import pre_if_stage_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, IF_allow_in = 1'b1;
  logic        br_taken = 1'b0, br_stall = 1'b0, csr_reset = 1'b0;
  logic [31:0] br_target = '0, csr_target = '0;
  logic        preIF_to_IF_valid, inst_sram_en;
  logic [31:0] to_IF_data, inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_we;
  logic [31:0] exp_q[$];
  logic [31:0] e, idle_pc = '0;
  logic        idle_chk = 1'b0, valid_low = 1'b0, done = 1'b0;
  int          n_cmp = 0, n_bad = 0;
`ifdef PREIF_FETCH_CNT_EN
  logic [31:0] fetch_cnt, redirect_cnt, exp_fetch = '0, exp_redir = '0;
  logic        cnt_chk = 1'b0;
`endif
  pre_if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .IF_allow_in       (IF_allow_in),
    .preIF_to_IF_valid (preIF_to_IF_valid),
    .to_IF_data        (to_IF_data),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .br_stall          (br_stall),
    .csr_reset         (csr_reset),
    .csr_target        (csr_target),
    .inst_sram_en      (inst_sram_en),
    .inst_sram_we      (inst_sram_we),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata)
`ifdef PREIF_FETCH_CNT_EN
    ,
    .fetch_cnt         (fetch_cnt),
    .redirect_cnt      (redirect_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (inst_sram_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL fetch_extra: got pc %h, required no fetch", to_IF_data);
      end else begin
        e = exp_q.pop_front();
        if (to_IF_data !== e || inst_sram_addr !== {e[31:2], 2'b00}) begin
          n_bad++;
          $display("FAIL fetch_pc: got pc %h addr %h, required pc %h addr %h", to_IF_data, inst_sram_addr, e, {e[31:2], 2'b00});
        end
      end
    end
    if (idle_chk) begin
      n_cmp++;
      if (inst_sram_en !== 1'b0 || to_IF_data !== idle_pc) begin
        n_bad++;
        $display("FAIL stall_hold: got en %b pc %h, required en 0 pc %h", inst_sram_en, to_IF_data, idle_pc);
      end
    end
    if (valid_low) begin
      n_cmp++;
      if (preIF_to_IF_valid !== 1'b0 || inst_sram_we !== 4'd0 || inst_sram_wdata !== 32'd0) begin
        n_bad++;
        $display("FAIL valid_low: got valid %b we %h wdata %h, required 0 0 0", preIF_to_IF_valid, inst_sram_we, inst_sram_wdata);
      end
    end
`ifdef PREIF_FETCH_CNT_EN
    if (cnt_chk) begin
      n_cmp++;
      if (fetch_cnt !== exp_fetch || redirect_cnt !== exp_redir) begin
        n_bad++;
        $display("FAIL counters: got %0d/%0d, required %0d/%0d", fetch_cnt, redirect_cnt, exp_fetch, exp_redir);
      end
    end
`endif
    if (done) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d fetches outstanding, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required end of run");
    $fatal(1);
  end
  initial begin
    repeat (2) tick;
    valid_low = 1'b1;
    idle_chk  = 1'b1;
    idle_pc   = RESET_PC;
`ifdef PREIF_FETCH_CNT_EN
    cnt_chk = 1'b1;
`endif
    tick;
    reset     = 1'b0;
    valid_low = 1'b0;
`ifdef PREIF_FETCH_CNT_EN
    cnt_chk = 1'b0;
`endif
    exp_q.push_back(32'h1c000000);
    exp_q.push_back(32'h1c000004);
    exp_q.push_back(32'h1c000008);
    exp_q.push_back(32'h1c00000c);
    tick;
    idle_chk = 1'b0;
    tick;
    tick;
    IF_allow_in = 1'b0;
    idle_chk    = 1'b1;
    idle_pc     = 32'h1c000008;
    repeat (2) tick;
    tick;
    IF_allow_in = 1'b1;
    idle_chk    = 1'b0;
    tick;
    exp_q.push_back(32'h1c000100);
    exp_q.push_back(32'h1c000104);
    tick;
    br_taken  = 1'b1;
    br_target = 32'h1c000100;
    tick;
    br_taken = 1'b0;
    exp_q.push_back(32'h1c000100);
    exp_q.push_back(32'h1c000104);
    tick;
    IF_allow_in = 1'b0;
    br_taken    = 1'b1;
    idle_chk    = 1'b1;
    idle_pc     = 32'h1c000100;
    tick;
    br_taken = 1'b0;
    tick;
    IF_allow_in = 1'b1;
    idle_chk    = 1'b0;
    tick;
    exp_q.push_back(32'h1c008000);
    exp_q.push_back(32'h1c008004);
    tick;
    IF_allow_in = 1'b0;
    idle_chk    = 1'b1;
    br_taken    = 1'b1;
    br_target   = 32'h1c000200;
    idle_pc     = 32'h1c000200;
    tick;
    br_taken   = 1'b0;
    csr_reset  = 1'b1;
    csr_target = 32'h1c008000;
    idle_pc    = 32'h1c008000;
    tick;
    csr_reset = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h1c000300;
    idle_pc   = 32'h1c000300;
    tick;
    br_taken = 1'b0;
    idle_pc  = 32'h1c008000;
    tick;
    IF_allow_in = 1'b1;
    idle_chk    = 1'b0;
    tick;
    exp_q.push_back(32'h1c008000);
    exp_q.push_back(32'h1c008004);
    tick;
    csr_reset  = 1'b1;
    csr_target = 32'h1c008000;
    br_taken   = 1'b1;
    br_target  = 32'h1c000100;
    tick;
    csr_reset = 1'b0;
    br_taken  = 1'b0;
    tick;
    br_stall  = 1'b1;
    idle_chk  = 1'b1;
    valid_low = 1'b1;
    idle_pc   = 32'h1c008008;
    exp_q.push_back(32'h1c00a000);
    exp_q.push_back(32'h1c00a004);
    tick;
    valid_low  = 1'b0;
    idle_chk   = 1'b0;
    csr_reset  = 1'b1;
    csr_target = 32'h1c00a000;
    tick;
    csr_reset = 1'b0;
    br_stall  = 1'b0;
    exp_q.push_back(32'h1c00b002);
    exp_q.push_back(32'h1c00b006);
    exp_q.push_back(32'hfffffffc);
    exp_q.push_back(32'h00000000);
    tick;
    csr_reset  = 1'b1;
    csr_target = 32'h1c00b002;
    tick;
    csr_reset = 1'b0;
    tick;
    csr_reset  = 1'b1;
    csr_target = 32'hfffffffc;
    tick;
    csr_reset = 1'b0;
    tick;
    IF_allow_in = 1'b0;
    br_taken    = 1'b1;
    br_target   = 32'h1c000500;
    idle_chk    = 1'b1;
    idle_pc     = 32'h1c000500;
    tick;
    br_taken = 1'b0;
    tick;
    reset     = 1'b1;
    idle_chk  = 1'b0;
    valid_low = 1'b1;
    tick;
    idle_chk    = 1'b1;
    idle_pc     = RESET_PC;
    IF_allow_in = 1'b1;
`ifdef PREIF_FETCH_CNT_EN
    exp_fetch = 32'd0;
    exp_redir = 32'd0;
    cnt_chk   = 1'b1;
`endif
    exp_q.push_back(32'h1c000000);
    exp_q.push_back(32'h1c000004);
    exp_q.push_back(32'h1c000008);
    tick;
    reset     = 1'b0;
    valid_low = 1'b0;
`ifdef PREIF_FETCH_CNT_EN
    cnt_chk = 1'b0;
`endif
    tick;
    idle_chk = 1'b0;
    tick;
    tick;
`ifdef PREIF_FETCH_CNT_EN
    exp_fetch = 32'd2;
    cnt_chk   = 1'b1;
`endif
    tick;
    IF_allow_in = 1'b0;
`ifdef PREIF_FETCH_CNT_EN
    cnt_chk = 1'b0;
`endif
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    done = 1'b1;
  end
endmodule
